reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised architectural register file with an integrated per-register write scoreboard.
//  - Two combinational read ports and one writeback port, with optional same-cycle write->read bypass.
//  - Dedicated PC register (index PC_IDX) with its own write port.
//  - Pending-write counters: decode reserves a destination, writeback retires it, busy flags drive stalls.
// PARAMETERS
//  DATA_W   16  register width in bits
//  NREG     8   number of registers
//  ADDR_W   3   address width; must equal clog2(NREG)
//  PC_IDX   0   index of the PC register
//  PEND_W   2   pending-counter width; max outstanding writes per reg = 2**PEND_W-1
//  BYPASS   1   1: same-cycle writeback forwarded to D1/D2/pc_out; 0: no forwarding
// PORTS
//  clk       in   1              clock, rising edge
//  rst       in   1              asynchronous active-high reset
//  A1        in   ADDR_W         read port 1 address
//  A2        in   ADDR_W         read port 2 address
//  D1        out  DATA_W         read data 1
//  D2        out  DATA_W         read data 2
//  busy1     out  1              A1 has a write outstanding after this cycle's retire
//  busy2     out  1              A2 has a write outstanding after this cycle's retire
//  wr_en     in   1              writeback enable
//  A3        in   ADDR_W         writeback address
//  Data_in   in   DATA_W         writeback data
//  pc_write  in   1              PC write enable
//  pc_in     in   DATA_W         next PC value
//  pc_out    out  DATA_W         contents of register PC_IDX
//  rsv_en    in   1              reserve destination (decode issue)
//  rsv_addr  in   ADDR_W         register to reserve
//  rsv_ok    out  1              reservation accepted (combinational)
//  flush     in   1              clear all pending counters
//  regs_flat out  NREG*DATA_W    debug; reg i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset:
//  - rst=1 asynchronously clears all registers and all pending counters.
//  - Outputs during/after reset: D1/D2/pc_out/regs_flat=0, busy1/busy2=0, rsv_ok=1.
//  Reads: combinational, 0-cycle latency.
//  - BYPASS=1: D1 returns Data_in when wr_en && A3==A1 (D2 likewise).
//  - BYPASS=1: pc_out and reads of PC_IDX return pc_in when pc_write=1; pc_in beats Data_in.
//  - BYPASS=0: reads return stored contents only.
//  Writes on rising clk:
//  - wr_en writes Data_in to reg[A3]; pc_write writes pc_in to reg[PC_IDX].
//  - Both target PC_IDX in the same cycle: pc_write wins.
//  Scoreboard (pend[i], PEND_W bits):
//  - rsv_ok = (pend[rsv_addr] != all-ones); a reservation is taken only when rsv_en && rsv_ok.
//  - Retire: wr_en decrements pend[A3] when nonzero; at 0 the write is untracked and the count stays 0.
//  - Reserve and retire on the same reg in one cycle: count unchanged.
//  - pc_write never changes pend.
//  - busy1 = (pend[A1] - (wr_en && A3==A1 && pend[A1]!=0)) != 0; busy2 likewise.
//  - With BYPASS=0, busy1/busy2 also assert on wr_en && A3==A1 (resp. A2), because the data is not forwarded.
//  - flush=1: every pend becomes 0 at the edge, overriding same-cycle rsv/retire count changes.
//    Data writes that cycle still occur.
//  - rsv_en=0 or an unaccepted request: no state change.
//  - Reset mid-operation discards all outstanding reservations.
// TESTING
//  T1 reset: assert rst async mid-cycle -> all regs_flat=0, pend=0, rsv_ok=1 without waiting for clk.
//  T2 bypass: reg3=0x1111; wr_en A3=3 Data_in=0xBEEF, A1=3 -> D1=0xBEEF same cycle, 0xBEEF stored.
//     Repeat with BYPASS=0 -> D1=0x1111, busy1=1.
//  T3 PC priority: wr_en A3=0 Data_in=0x00AA, pc_write pc_in=0x0042 -> pc_out=0x0042 after edge.
//  T4 saturation: 3x rsv_en addr 5 -> rsv_ok=1 each; 4th -> rsv_ok=0, pend[5] stays 3.
//     3x wr_en A3=5 -> busy1(A1=5)=1,1,0 in the retire cycles.
//  T5 simultaneous: pend[2]=1; rsv_en addr 2 + wr_en A3=2 same cycle -> pend[2] stays 1, busy asserted.
//  T6 flush: pend[1]=2, pend[4]=1; flush + rsv_en addr 6 -> all pend 0, busy low next cycle, data writes land.

Source files
------------

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Purpose  : Architectural register file with an integrated per-register
//            pending-write scoreboard. Two combinational read ports, one
//            writeback port, a dedicated PC write port, and optional
//            same-cycle writeback forwarding.
// Ports    : clk, rst            - clock (rising edge), async active-high reset
//            A1/A2 -> D1/D2      - combinational read ports
//            busy1/busy2         - read address still has a write outstanding
//                                  after this cycle's retire
//            wr_en/A3/Data_in    - writeback port (also retires a reservation)
//            pc_write/pc_in      - PC register write port, pc_out its contents
//            rsv_en/rsv_addr     - reserve a destination, rsv_ok = accepted
//            flush               - clear every pending counter
//            regs_flat           - debug view, reg i at [i*DATA_W +: DATA_W]
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3,
    parameter int PC_IDX = 0,
    parameter int PEND_W = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      A1,
    input  logic [ADDR_W-1:0]      A2,
    output logic [DATA_W-1:0]      D1,
    output logic [DATA_W-1:0]      D2,
    output logic                   busy1,
    output logic                   busy2,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      A3,
    input  logic [DATA_W-1:0]      Data_in,
    input  logic                   pc_write,
    input  logic [DATA_W-1:0]      pc_in,
    output logic [DATA_W-1:0]      pc_out,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic                   rsv_ok,
    input  logic                   flush,
    output logic [NREG*DATA_W-1:0] regs_flat
);

    localparam logic [ADDR_W-1:0] c_PC_ADDR  = ADDR_W'(PC_IDX);
    localparam logic [PEND_W-1:0] c_PEND_MAX = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];

    logic w_hit1;
    logic w_hit2;
    logic w_ret1;
    logic w_ret2;
    logic w_rsv_take;
    logic w_retire;

    // ------------------------------------------------------------------
    // Reads: stored value, optionally overridden by this cycle's writes.
    // pc_in is applied last so it beats Data_in on the PC register.
    // ------------------------------------------------------------------
    always_comb begin
        D1     = regs_q[A1];
        D2     = regs_q[A2];
        pc_out = regs_q[c_PC_ADDR];
        if (BYPASS != 0) begin
            if (wr_en && (A3 == A1))           D1 = Data_in;
            if (pc_write && (A1 == c_PC_ADDR)) D1 = pc_in;
            if (wr_en && (A3 == A2))           D2 = Data_in;
            if (pc_write && (A2 == c_PC_ADDR)) D2 = pc_in;
            if (wr_en && (A3 == c_PC_ADDR))    pc_out = Data_in;
            if (pc_write)                      pc_out = pc_in;
        end
    end

    // ------------------------------------------------------------------
    // Busy flags look past this cycle's retire. Without forwarding, a
    // same-cycle writeback to the read address must also stall because
    // the reader would see stale data.
    // ------------------------------------------------------------------
    always_comb begin
        w_hit1 = wr_en && (A3 == A1);
        w_hit2 = wr_en && (A3 == A2);
        w_ret1 = w_hit1 && (pend_q[A1] != '0);
        w_ret2 = w_hit2 && (pend_q[A2] != '0);
        busy1  = (pend_q[A1] - PEND_W'(w_ret1)) != '0;
        busy2  = (pend_q[A2] - PEND_W'(w_ret2)) != '0;
        if (BYPASS == 0) begin
            busy1 = busy1 || w_hit1;
            busy2 = busy2 || w_hit2;
        end
    end

    assign rsv_ok = (pend_q[rsv_addr] != c_PEND_MAX);

    // ------------------------------------------------------------------
    // Next-state for data registers: pc_write applied after wr_en so it
    // wins when both target the PC register.
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (wr_en)    regs_d[A3]        = Data_in;
        if (pc_write) regs_d[c_PC_ADDR] = pc_in;
    end

    // ------------------------------------------------------------------
    // Next-state for pending counters. The increment reads pend_q while
    // the decrement reads pend_d, so a reserve and retire on the same
    // register cancel. rsv_ok guarantees the increment cannot wrap, and
    // the retire only fires on a nonzero count so it cannot underflow.
    // ------------------------------------------------------------------
    always_comb begin
        pend_d     = pend_q;
        w_rsv_take = rsv_en && rsv_ok;
        w_retire   = wr_en && (pend_q[A3] != '0);
        if (w_rsv_take) pend_d[rsv_addr] = pend_q[rsv_addr] + PEND_W'(1);
        if (w_retire)   pend_d[A3]       = pend_d[A3] - PEND_W'(1);
        if (flush) begin
            for (int i = 0; i < NREG; i++) pend_d[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
        assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Purpose  : Directed scoreboard bench for reg_file_sb. Two instances share
//            stimulus: one with forwarding, one without. Stimulus queues the
//            expected observations; the monitor compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;

    // observation selectors
    localparam int S_D1     = 0;
    localparam int S_D2     = 1;
    localparam int S_BUSY1  = 2;
    localparam int S_BUSY2  = 3;
    localparam int S_PC     = 4;
    localparam int S_RSVOK  = 5;
    localparam int S_WORD   = 6;
    localparam int S_NB_D1  = 7;
    localparam int S_NB_B1  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] A1, A2, A3, rsv_addr;
    logic [DW-1:0] Data_in, pc_in;
    logic          wr_en, pc_write, rsv_en, flush;

    logic [DW-1:0]    D1, D2, pc_out;
    logic             busy1, busy2, rsv_ok;
    logic [NR*DW-1:0] regs_flat;

    logic [DW-1:0]    nb_D1, nb_D2, nb_pc_out;
    logic             nb_busy1, nb_busy2, nb_rsv_ok;
    logic [NR*DW-1:0] nb_regs_flat;

    typedef struct {
        string       name;
        int          sel;
        int          idx;
        logic [15:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DW), .NREG(NR), .ADDR_W(AW), .PC_IDX(0), .PEND_W(2), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .D1(D1), .D2(D2),
        .busy1(busy1), .busy2(busy2), .wr_en(wr_en), .A3(A3), .Data_in(Data_in),
        .pc_write(pc_write), .pc_in(pc_in), .pc_out(pc_out), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .flush(flush), .regs_flat(regs_flat)
    );

    reg_file_sb #(.DATA_W(DW), .NREG(NR), .ADDR_W(AW), .PC_IDX(0), .PEND_W(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .D1(nb_D1), .D2(nb_D2),
        .busy1(nb_busy1), .busy2(nb_busy2), .wr_en(wr_en), .A3(A3), .Data_in(Data_in),
        .pc_write(pc_write), .pc_in(pc_in), .pc_out(nb_pc_out), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_ok(nb_rsv_ok), .flush(flush), .regs_flat(nb_regs_flat)
    );

    function automatic logic [15:0] observe(input int sel, input int idx);
        case (sel)
            S_D1:    return D1;
            S_D2:    return D2;
            S_BUSY1: return {15'd0, busy1};
            S_BUSY2: return {15'd0, busy2};
            S_PC:    return pc_out;
            S_RSVOK: return {15'd0, rsv_ok};
            S_WORD:  return regs_flat[idx*DW +: DW];
            S_NB_D1: return nb_D1;
            S_NB_B1: return {15'd0, nb_busy1};
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input int idx, input logic [15:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.idx  = idx;
        e.exp  = v;
        q.push_back(e);
    endtask

    // Monitor: compares everything queued for this cycle on the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e   = q.pop_front();
            act = observe(e.sel, e.idx);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    // Advance to just after the next rising edge and return controls to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        pc_write = 1'b0;
        rsv_en   = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        A1 = '0; A2 = '0; A3 = '0; rsv_addr = '0;
        Data_in = '0; pc_in = '0;
        wr_en = 1'b0; pc_write = 1'b0; rsv_en = 1'b0; flush = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // post-reset state
        A1 = 3'd0; A2 = 3'd5; rsv_addr = 3'd5;
        expect_val("rst_D1", S_D1, 0, 16'h0000);
        expect_val("rst_pc", S_PC, 0, 16'h0000);
        expect_val("rst_busy1", S_BUSY1, 0, 16'h0);
        expect_val("rst_rsvok", S_RSVOK, 0, 16'h1);

        // T2 bypass: preload reg3, then overwrite while reading it
        next_cycle();
        wr_en = 1'b1; A3 = 3'd3; Data_in = 16'h1111;
        next_cycle();
        wr_en = 1'b1; A3 = 3'd3; Data_in = 16'hBEEF; A1 = 3'd3;
        expect_val("byp_D1", S_D1, 0, 16'hBEEF);
        expect_val("byp_busy1", S_BUSY1, 0, 16'h0);
        expect_val("nobyp_D1", S_NB_D1, 0, 16'h1111);
        expect_val("nobyp_busy1", S_NB_B1, 0, 16'h1);
        next_cycle();
        A1 = 3'd3;
        expect_val("byp_stored", S_WORD, 3, 16'hBEEF);
        expect_val("nobyp_stored_D1", S_NB_D1, 0, 16'hBEEF);
        expect_val("nobyp_busy1_idle", S_NB_B1, 0, 16'h0);

        // T3 PC priority over writeback to the PC register
        next_cycle();
        wr_en = 1'b1; A3 = 3'd0; Data_in = 16'h00AA;
        pc_write = 1'b1; pc_in = 16'h0042; A1 = 3'd0;
        expect_val("pcprio_D1", S_D1, 0, 16'h0042);
        expect_val("pcprio_pc_byp", S_PC, 0, 16'h0042);
        next_cycle();
        expect_val("pcprio_pc", S_PC, 0, 16'h0042);
        expect_val("pcprio_word0", S_WORD, 0, 16'h0042);

        // T4 saturation on reg5
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            rsv_en = 1'b1; rsv_addr = 3'd5; A1 = 3'd5;
            expect_val($sformatf("sat_rsvok%0d", k), S_RSVOK, 0, 16'h1);
        end
        next_cycle();
        rsv_en = 1'b1; rsv_addr = 3'd5; A1 = 3'd5;
        expect_val("sat_rsvok_full", S_RSVOK, 0, 16'h0);
        expect_val("sat_busy_full", S_BUSY1, 0, 16'h1);
        next_cycle();
        rsv_addr = 3'd5;
        expect_val("sat_stays3", S_RSVOK, 0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            wr_en = 1'b1; A3 = 3'd5; Data_in = 16'h5001 + 16'(k); A1 = 3'd5;
            expect_val($sformatf("ret_busy%0d", k), S_BUSY1, 0, (k < 2) ? 16'h1 : 16'h0);
        end
        expect_val("ret_D1_byp", S_D1, 0, 16'h5003);
        next_cycle();
        A1 = 3'd5; rsv_addr = 3'd5;
        expect_val("ret_idle_busy", S_BUSY1, 0, 16'h0);
        expect_val("ret_idle_rsvok", S_RSVOK, 0, 16'h1);
        expect_val("ret_D1", S_D1, 0, 16'h5003);

        // T5 reserve + retire same register
        next_cycle();
        rsv_en = 1'b1; rsv_addr = 3'd2;
        next_cycle();
        rsv_en = 1'b1; rsv_addr = 3'd2;
        wr_en = 1'b1; A3 = 3'd2; Data_in = 16'h2222; A1 = 3'd2;
        expect_val("sim_rsvok", S_RSVOK, 0, 16'h1);
        expect_val("sim_busy_now", S_BUSY1, 0, 16'h0);
        next_cycle();
        A1 = 3'd2;
        expect_val("sim_busy_after", S_BUSY1, 0, 16'h1);
        expect_val("sim_word2", S_WORD, 2, 16'h2222);
        next_cycle();
        wr_en = 1'b1; A3 = 3'd2; Data_in = 16'h2223; A1 = 3'd2;
        expect_val("sim_final_retire", S_BUSY1, 0, 16'h0);
        next_cycle();
        A1 = 3'd2;
        expect_val("sim_idle", S_BUSY1, 0, 16'h0);

        // T6 flush: pend1=2, pend4=1
        next_cycle(); rsv_en = 1'b1; rsv_addr = 3'd1;
        next_cycle(); rsv_en = 1'b1; rsv_addr = 3'd1;
        next_cycle(); rsv_en = 1'b1; rsv_addr = 3'd4;
        next_cycle();
        A1 = 3'd1; A2 = 3'd4;
        expect_val("fl_pre_busy1", S_BUSY1, 0, 16'h1);
        expect_val("fl_pre_busy2", S_BUSY2, 0, 16'h1);
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 3'd6;
        wr_en = 1'b1; A3 = 3'd7; Data_in = 16'h7777;
        expect_val("fl_rsvok", S_RSVOK, 0, 16'h1);
        next_cycle();
        A1 = 3'd1; A2 = 3'd4;
        expect_val("fl_busy1", S_BUSY1, 0, 16'h0);
        expect_val("fl_busy2", S_BUSY2, 0, 16'h0);
        expect_val("fl_word7", S_WORD, 7, 16'h7777);
        next_cycle();
        A1 = 3'd6; A2 = 3'd7;
        expect_val("fl_busy6", S_BUSY1, 0, 16'h0);
        expect_val("fl_D2", S_D2, 0, 16'h7777);

        // T1 async reset: fill reg3's counter, then reset between edges
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            rsv_en = 1'b1; rsv_addr = 3'd3;
        end
        next_cycle();
        A1 = 3'd3; rsv_addr = 3'd3;
        expect_val("ar_pre_rsvok", S_RSVOK, 0, 16'h0);
        expect_val("ar_pre_busy", S_BUSY1, 0, 16'h1);
        expect_val("ar_pre_word3", S_WORD, 3, 16'hBEEF);
        next_cycle();
        rst = 1'b1;
        A1 = 3'd3; rsv_addr = 3'd3;
        expect_val("ar_word3", S_WORD, 3, 16'h0000);
        expect_val("ar_word7", S_WORD, 7, 16'h0000);
        expect_val("ar_pc", S_PC, 0, 16'h0000);
        expect_val("ar_D1", S_D1, 0, 16'h0000);
        expect_val("ar_busy1", S_BUSY1, 0, 16'h0);
        expect_val("ar_rsvok", S_RSVOK, 0, 16'h1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
